// File: rtl/csm_pkg.sv
// Shared types for the CSM shared-memory responder.
// Port FSM states, lock owner encoding and error codes.
package csm_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_RD,
    P_WR_DATA,
    P_WR_WAIT,
    P_LOCK,
    P_REL
  } port_state_t;

  typedef enum logic [1:0] {
    FREE,
    OWN_A,
    OWN_B
  } lock_owner_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_BADREL   = 2'b01;
  localparam logic [1:0] ERR_REHOLD   = 2'b10;
  localparam logic [1:0] ERR_CONFLICT = 2'b11;

endpackage

// File: rtl/csm_port_fsm.sv
// Per-processor port controller for the CSM responder.
// Sequences reads, two-phase writes and lock hold/release.
module csm_port_fsm
  import csm_pkg::*;
#(
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATABITS-1:0] in_ad,
  input  logic                rw,
  input  logic                enable,
  input  logic                hold,
  input  logic                rel,
  input  logic                blocked,
  input  logic                own,
  input  logic                lock_gnt,
  input  logic [DATABITS-1:0] rdata,
  output logic                ack,
  output logic [ERRBITS-1:0]  err,
  output logic [DATABITS-1:0] out_data,
  output logic [DATABITS-1:0] addr,
  output logic                wr_en,
  output logic [DATABITS-1:0] wr_data,
  output logic                lock_req,
  output logic                rel_req
);

  port_state_t         state_q, state_d;
  logic [ERRBITS-1:0]  err_q, err_d;
  logic [DATABITS-1:0] out_q, out_d;
  logic [DATABITS-1:0] addr_q, addr_d;
  logic [DATABITS-1:0] data_q, data_d;

  // Next-state and completion status for the port.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    out_d   = out_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      P_IDLE: begin
        if (enable) begin
          if (hold && rel) begin
            err_d = ERRBITS'(ERR_CONFLICT);
          end else if (hold) begin
            state_d = P_LOCK;
          end else if (rel) begin
            state_d = P_REL;
          end else begin
            addr_d  = in_ad;
            state_d = rw ? P_WR_DATA : P_RD;
          end
        end
      end
      P_RD: begin
        if (!blocked) begin
          out_d   = rdata;
          err_d   = ERRBITS'(ERR_OK);
          state_d = P_IDLE;
        end
      end
      P_WR_DATA: begin
        data_d = in_ad;
        if (!blocked) begin
          err_d   = ERRBITS'(ERR_OK);
          state_d = P_IDLE;
        end else begin
          state_d = P_WR_WAIT;
        end
      end
      P_WR_WAIT: begin
        if (!blocked) begin
          err_d   = ERRBITS'(ERR_OK);
          state_d = P_IDLE;
        end
      end
      P_LOCK: begin
        if (own) begin
          err_d   = ERRBITS'(ERR_REHOLD);
          state_d = P_IDLE;
        end else if (lock_gnt) begin
          err_d   = ERRBITS'(ERR_OK);
          state_d = P_IDLE;
        end
      end
      P_REL: begin
        err_d   = own ? ERRBITS'(ERR_OK)
                      : ERRBITS'(ERR_BADREL);
        state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  // Port state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      err_q   <= '0;
      out_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      out_q   <= out_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ack      = (state_q == P_IDLE);
  assign err      = err_q;
  assign out_data = out_q;
  assign addr     = addr_q;
  assign wr_en    = ((state_q == P_WR_DATA) ||
                     (state_q == P_WR_WAIT)) && !blocked;
  assign wr_data  = (state_q == P_WR_DATA) ? in_ad : data_q;
  assign lock_req = (state_q == P_LOCK);
  assign rel_req  = (state_q == P_REL);

endmodule

// File: rtl/csm_responder.sv
// CSM bus shared-memory responder: two port FSMs,
// one dual-port memory and a single A-priority lock.
module csm_responder
  import csm_pkg::*;
#(
  parameter int DATABITS = 8,
  parameter int ERRBITS  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATABITS-1:0] A_in_AD,
  input  logic                A_rw,
  input  logic                A_enable,
  input  logic                A_hold,
  input  logic                A_release,
  output logic                A_ack,
  output logic [ERRBITS-1:0]  A_err,
  output logic [DATABITS-1:0] A_out_data,
  input  logic [DATABITS-1:0] B_in_AD,
  input  logic                B_rw,
  input  logic                B_enable,
  input  logic                B_hold,
  input  logic                B_release,
  output logic                B_ack,
  output logic [ERRBITS-1:0]  B_err,
  output logic [DATABITS-1:0] B_out_data
);

  localparam int DEPTH = 1 << DATABITS;

  logic [DATABITS-1:0] mem_q [DEPTH];
  logic [DATABITS-1:0] mem_d [DEPTH];
  lock_owner_t         owner_q, owner_d;

  logic [DATABITS-1:0] a_addr, b_addr;
  logic [DATABITS-1:0] a_wdata, b_wdata;
  logic                a_wr, b_wr;
  logic                a_lreq, b_lreq;
  logic                a_rreq, b_rreq;
  logic                a_blk, b_blk;
  logic                a_own, b_own;
  logic                a_gnt, b_gnt;

  assign a_blk = (owner_q == OWN_B);
  assign b_blk = (owner_q == OWN_A);
  assign a_own = (owner_q == OWN_A);
  assign b_own = (owner_q == OWN_B);
  assign a_gnt = (owner_q == FREE);
  assign b_gnt = (owner_q == FREE) && !a_lreq;

  csm_port_fsm #(
    .DATABITS (DATABITS),
    .ERRBITS  (ERRBITS)
  ) u_port_a (
    .clk      (clk),
    .rst_n    (reset_n),
    .in_ad    (A_in_AD),
    .rw       (A_rw),
    .enable   (A_enable),
    .hold     (A_hold),
    .rel      (A_release),
    .blocked  (a_blk),
    .own      (a_own),
    .lock_gnt (a_gnt),
    .rdata    (mem_q[a_addr]),
    .ack      (A_ack),
    .err      (A_err),
    .out_data (A_out_data),
    .addr     (a_addr),
    .wr_en    (a_wr),
    .wr_data  (a_wdata),
    .lock_req (a_lreq),
    .rel_req  (a_rreq)
  );

  csm_port_fsm #(
    .DATABITS (DATABITS),
    .ERRBITS  (ERRBITS)
  ) u_port_b (
    .clk      (clk),
    .rst_n    (reset_n),
    .in_ad    (B_in_AD),
    .rw       (B_rw),
    .enable   (B_enable),
    .hold     (B_hold),
    .rel      (B_release),
    .blocked  (b_blk),
    .own      (b_own),
    .lock_gnt (b_gnt),
    .rdata    (mem_q[b_addr]),
    .ack      (B_ack),
    .err      (B_err),
    .out_data (B_out_data),
    .addr     (b_addr),
    .wr_en    (b_wr),
    .wr_data  (b_wdata),
    .lock_req (b_lreq),
    .rel_req  (b_rreq)
  );

  // Lock ownership; A wins when both request a free lock.
  always_comb begin
    owner_d = owner_q;
    unique case (owner_q)
      FREE: begin
        if (a_lreq)      owner_d = OWN_A;
        else if (b_lreq) owner_d = OWN_B;
      end
      OWN_A:   if (a_rreq) owner_d = FREE;
      OWN_B:   if (b_rreq) owner_d = FREE;
      default: owner_d = FREE;
    endcase
  end

  // Memory update; A written last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (b_wr) mem_d[b_addr] = b_wdata;
    if (a_wr) mem_d[a_addr] = a_wdata;
  end

  // Lock owner and memory storage, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= FREE;
      mem_q   <= '{default: '0};
    end else begin
      owner_q <= owner_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_csm_responder.sv
// Directed bench for csm_responder: read-back scoreboard
// plus ack/err/lock behaviour checks.
module tb_csm_responder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] A_in_AD, B_in_AD;
  logic       A_rw, B_rw, A_enable, B_enable;
  logic       A_hold, B_hold, A_release, B_release;
  logic       A_ack, B_ack;
  logic [1:0] A_err, B_err;
  logic [7:0] A_out_data, B_out_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         port_b;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  csm_responder #(
    .DATABITS (8),
    .ERRBITS  (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .A_in_AD    (A_in_AD),
    .A_rw       (A_rw),
    .A_enable   (A_enable),
    .A_hold     (A_hold),
    .A_release  (A_release),
    .A_ack      (A_ack),
    .A_err      (A_err),
    .A_out_data (A_out_data),
    .B_in_AD    (B_in_AD),
    .B_rw       (B_rw),
    .B_enable   (B_enable),
    .B_hold     (B_hold),
    .B_release  (B_release),
    .B_ack      (B_ack),
    .B_err      (B_err),
    .B_out_data (B_out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(logic en, logic rw, logic [7:0] ad,
                       logic h, logic r);
    A_enable = en; A_rw = rw; A_in_AD = ad;
    A_hold = h; A_release = r;
  endtask

  task automatic b_set(logic en, logic rw, logic [7:0] ad,
                       logic h, logic r);
    B_enable = en; B_rw = rw; B_in_AD = ad;
    B_hold = h; B_release = r;
  endtask

  task automatic push_rd(bit pb, logic [7:0] d);
    exp_t e;
    e.port_b = pb;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic pop_rd(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk(tag, e.port_b ? B_out_data : A_out_data, e.data);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    a_set(0, 0, 8'h00, 0, 0);
    b_set(0, 0, 8'h00, 0, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    chk("rst_a_ack", A_ack, 1);
    chk("rst_b_ack", B_ack, 1);
    chk("rst_a_err", A_err, 0);
    chk("rst_b_out", B_out_data, 0);

    // A writes 0x5A to 0x10, B reads it back
    a_set(1, 1, 8'h10, 0, 0);
    tick();
    chk("wr_a_ack_low", A_ack, 0);
    a_set(0, 0, 8'h5A, 0, 0);
    tick();
    chk("wr_a_ack_high", A_ack, 1);
    chk("wr_a_err", A_err, 0);
    a_set(0, 0, 8'h00, 0, 0);
    push_rd(1, 8'h5A);
    b_set(1, 0, 8'h10, 0, 0);
    tick();
    chk("rd_b_ack_low", B_ack, 0);
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("rd_b_ack_high", B_ack, 1);
    chk("rd_b_err", B_err, 0);
    pop_rd("rd_b_5a");

    // A holds, B write to 0x20 stalls until release
    a_set(1, 0, 8'h00, 1, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("hold_a_err", A_err, 0);
    b_set(1, 1, 8'h20, 0, 0);
    tick();
    b_set(0, 0, 8'h33, 0, 0);
    tick();
    b_set(0, 0, 8'hEE, 0, 0);
    chk("blk_b_ack0", B_ack, 0);
    repeat (3) tick();
    chk("blk_b_ack1", B_ack, 0);
    a_set(1, 0, 8'h00, 0, 1);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("rel_a_err", A_err, 0);
    chk("rel_b_still_low", B_ack, 0);
    tick();
    chk("wr_b_commit_ack", B_ack, 1);
    chk("wr_b_commit_err", B_err, 0);
    push_rd(0, 8'h33);
    a_set(1, 0, 8'h20, 0, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    pop_rd("rd_a_33");

    // bad release, redundant hold
    b_set(1, 0, 8'h00, 0, 1);
    tick();
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("badrel_b_err", B_err, 2'b01);
    a_set(1, 0, 8'h00, 1, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("hold1_a_err", A_err, 2'b00);
    a_set(1, 0, 8'h00, 1, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("rehold_a_err", A_err, 2'b10);
    chk("rehold_a_ack", A_ack, 1);
    push_rd(1, 8'h33);
    b_set(1, 0, 8'h20, 0, 0);
    tick();
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("still_own_a", B_ack, 0);
    a_set(1, 0, 8'h00, 0, 1);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("rel2_b_low", B_ack, 0);
    tick();
    chk("rel2_b_done", B_ack, 1);
    pop_rd("rd_b_33");

    // simultaneous hold: A granted, B waits
    a_set(1, 0, 8'h00, 1, 0);
    b_set(1, 0, 8'h00, 1, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("dual_a_ack", A_ack, 1);
    chk("dual_a_err", A_err, 0);
    chk("dual_b_wait", B_ack, 0);
    tick();
    chk("dual_b_wait2", B_ack, 0);
    a_set(1, 0, 8'h00, 0, 1);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("dual_b_wait3", B_ack, 0);
    tick();
    chk("dual_b_gnt", B_ack, 1);
    chk("dual_b_err", B_err, 0);
    push_rd(0, 8'h33);
    a_set(1, 0, 8'h20, 0, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("own_b_a_blk", A_ack, 0);
    b_set(1, 0, 8'h00, 0, 1);
    tick();
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("rel_b_err", B_err, 0);
    chk("rel_b_a_low", A_ack, 0);
    tick();
    chk("rel_b_a_done", A_ack, 1);
    pop_rd("rd_a_after_b");

    // same-address write collision, read-during-write
    a_set(1, 1, 8'h40, 0, 0);
    b_set(1, 1, 8'h40, 0, 0);
    tick();
    a_set(0, 0, 8'h11, 0, 0);
    b_set(0, 0, 8'h22, 0, 0);
    tick();
    chk("coll_a_ack", A_ack, 1);
    chk("coll_b_ack", B_ack, 1);
    push_rd(0, 8'h11);
    a_set(1, 0, 8'h40, 0, 0);
    b_set(1, 1, 8'h40, 0, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    b_set(0, 0, 8'h77, 0, 0);
    tick();
    pop_rd("rdw_a_old");
    b_set(0, 0, 8'h00, 0, 0);
    push_rd(1, 8'h77);
    b_set(1, 0, 8'h40, 0, 0);
    tick();
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    pop_rd("rd_b_77");

    // reset while B stalled in write wait
    a_set(1, 0, 8'h00, 1, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    a_set(1, 0, 8'h00, 1, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("pre_rst_a_err", A_err, 2'b10);
    b_set(1, 1, 8'h60, 0, 0);
    tick();
    b_set(0, 0, 8'h55, 0, 0);
    tick();
    tick();
    chk("pre_rst_b_wait", B_ack, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_a_ack", A_ack, 1);
    chk("arst_b_ack", B_ack, 1);
    chk("arst_a_err", A_err, 0);
    chk("arst_b_out", B_out_data, 0);
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    reset_n = 1'b1;
    tick();
    push_rd(1, 8'h00);
    b_set(1, 0, 8'h60, 0, 0);
    tick();
    b_set(0, 0, 8'h00, 0, 0);
    tick();
    chk("post_rst_free", B_ack, 1);
    pop_rd("rd_b_60_zero");
    push_rd(0, 8'h00);
    a_set(1, 0, 8'h40, 0, 0);
    tick();
    a_set(0, 0, 8'h00, 0, 0);
    tick();
    pop_rd("rd_a_40_zero");

    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
